// File: rtl/timer_pkg.sv
// Shared types and limits for the MM:SS countdown timer.
// The top level guards its prescaler with `TIMER_PRESCALER_EN.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_UNIT     = 4'd9;
  localparam bcd_t MAX_SEC_TENS = 4'd5;

  // Action taken on a clock edge once reset has been ruled out.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_unit;
    bcd_t sec_tens;
    bcd_t sec_unit;
  } mmss_t;

  function automatic bcd_t clamp_bcd(input bcd_t value, input bcd_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: decrements when asked and wraps to its
// maximum with a borrow out when it was already zero.
module bcd_down_digit (
  input  logic [3:0] cur,
  input  logic       dec,
  input  logic [3:0] max,
  output logic [3:0] digit,
  output logic       borrow
);

  assign borrow = dec && (cur == 4'd0);

  // NOTE: the default assignment first means every path assigns digit, so no latch is inferred.
  always_comb begin
    digit = cur;
    if (dec) begin
      digit = (cur == 4'd0) ? max : (cur - 4'd1);
    end
  end

endmodule

// File: rtl/timer_controller.sv
// MM:SS BCD countdown timer with shift-in loading and a sticky done flag.
// Define TIMER_PRESCALER_EN to divide the tick by TICK_DIV; otherwise it ticks every clk.
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enablen,
  input  logic       load,
  input  logic [3:0] in,
  output logic [3:0] out_second_unit,
  output logic [3:0] out_second_tens,
  output logic [3:0] out_minute_unit,
  output logic [3:0] out_minute_tens,
  output logic       finished
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("timer_controller: TICK_DIV must be at least 1");
  end

  mmss_t r_time;
  logic  r_finished;

  mmss_t w_next_time;
  logic  w_next_finished;
  mmss_t w_shifted;
  mmss_t w_decremented;
  op_t   w_op;
  logic  w_run;
  logic  w_tick;
  logic  w_underflow;

  bcd_t  w_cur   [4];
  bcd_t  w_max   [4];
  bcd_t  w_dec   [4];
  logic  w_borrow [5];

  assign w_run = !load && !enablen;

`ifdef TIMER_PRESCALER_EN
  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PSC_W-1:0] r_psc;
  logic             w_psc_hit;
  logic             w_at_zero;

  assign w_at_zero = (r_time == '0);
  assign w_psc_hit = (r_psc == PSC_W'(TICK_DIV - 1));
  assign w_tick    = w_run && w_psc_hit;

  // The prescaler only advances while the timer is actually counting down.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_psc <= '0;
    end else if (w_run && !w_at_zero) begin
      r_psc <= w_psc_hit ? '0 : (r_psc + 1'b1);
    end
  end
`else
  assign w_tick = w_run;
`endif

  // Digit chain, least significant first: sec_unit, sec_tens, min_unit, min_tens.
  assign w_cur[0] = r_time.sec_unit;
  assign w_cur[1] = r_time.sec_tens;
  assign w_cur[2] = r_time.min_unit;
  assign w_cur[3] = r_time.min_tens;
  assign w_max[0] = MAX_UNIT;
  assign w_max[1] = MAX_SEC_TENS;
  assign w_max[2] = MAX_UNIT;
  assign w_max[3] = MAX_UNIT;
  assign w_borrow[0] = w_tick;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_down_digit u_digit (
      .cur    (w_cur[g]),
      .dec    (w_borrow[g]),
      .max    (w_max[g]),
      .digit  (w_dec[g]),
      .borrow (w_borrow[g+1])
    );
  end

  // A borrow out of the minutes tens means the value was already 00:00.
  assign w_underflow = w_borrow[4];

  assign w_decremented = '{
    min_tens: w_dec[3],
    min_unit: w_dec[2],
    sec_tens: w_dec[1],
    sec_unit: w_dec[0]
  };

  assign w_shifted = '{
    min_tens: r_time.min_unit,
    min_unit: clamp_bcd(r_time.sec_tens, MAX_UNIT),
    sec_tens: clamp_bcd(r_time.sec_unit, MAX_SEC_TENS),
    sec_unit: clamp_bcd(in, MAX_UNIT)
  };

  always_comb begin
    w_op = OP_HOLD;
    if (load) begin
      w_op = OP_LOAD;
    end else if (w_tick && !w_underflow) begin
      w_op = OP_COUNT;
    end
  end

  always_comb begin
    w_next_time     = r_time;
    w_next_finished = r_finished;
    case (w_op)
      OP_LOAD: begin
        w_next_time     = w_shifted;
        w_next_finished = 1'b0;
      end
      OP_COUNT: begin
        w_next_time = w_decremented;
        if (w_decremented == '0) begin
          w_next_finished = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_time     <= '0;
      r_finished <= 1'b0;
    end else begin
      r_time     <= w_next_time;
      r_finished <= w_next_finished;
    end
  end

  assign out_second_unit = r_time.sec_unit;
  assign out_second_tens = r_time.sec_tens;
  assign out_minute_unit = r_time.min_unit;
  assign out_minute_tens = r_time.min_tens;
  assign finished        = r_finished;

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller: directed scenarios then random
// stimulus, checked against a seconds-based reference model.
module tb_timer_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       enablen;
  logic       load;
  logic [3:0] in_d;
  logic [3:0] out_second_unit;
  logic [3:0] out_second_tens;
  logic [3:0] out_minute_unit;
  logic [3:0] out_minute_tens;
  logic       finished;

  typedef struct {
    int mt;
    int mu;
    int st;
    int su;
    bit fin;
  } exp_t;

  exp_t q[$];
  exp_t m = '{0, 0, 0, 0, 1'b0};
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  timer_controller dut (
    .clk             (clk),
    .rst             (rst),
    .enablen         (enablen),
    .load            (load),
    .in              (in_d),
    .out_second_unit (out_second_unit),
    .out_second_tens (out_second_tens),
    .out_minute_unit (out_minute_unit),
    .out_minute_tens (out_minute_tens),
    .finished        (finished)
  );

  always #5 clk = ~clk;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: loads shift digits with clamps; counting works on total seconds.
  function automatic void model_step(input bit r, input bit l, input int d, input bit en);
    int secs;
    if (r) begin
      m = '{0, 0, 0, 0, 1'b0};
    end else if (l) begin
      m.mt  = m.mu;
      m.mu  = min_int(m.st, 9);
      m.st  = min_int(m.su, 5);
      m.su  = min_int(d, 9);
      m.fin = 1'b0;
    end else if (!en) begin
      secs = (m.mt * 10 + m.mu) * 60 + m.st * 10 + m.su;
      if (secs > 0) begin
        secs = secs - 1;
        m.mt = (secs / 60) / 10;
        m.mu = (secs / 60) % 10;
        m.st = (secs % 60) / 10;
        m.su = (secs % 60) % 10;
        if (secs == 0) m.fin = 1'b1;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit l, input int d, input bit en);
    @(negedge clk);
    rst     = r;
    load    = l;
    in_d    = d[3:0];
    enablen = en;
    model_step(r, l, d, en);
    q.push_back(m);
  endtask

  // Monitor: the outputs are a new registered value after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        step_no++;
        checks++;
        if (out_minute_tens !== e.mt[3:0] || out_minute_unit !== e.mu[3:0] ||
            out_second_tens !== e.st[3:0] || out_second_unit !== e.su[3:0] ||
            finished !== e.fin) begin
          errors++;
          $display("FAIL step%0d: got %0d%0d:%0d%0d fin=%0b expected %0d%0d:%0d%0d fin=%0b",
                   step_no, out_minute_tens, out_minute_unit, out_second_tens,
                   out_second_unit, finished, e.mt, e.mu, e.st, e.su, e.fin);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    enablen = 1'b1;
    in_d    = 4'd0;

    drive(1, 0, 0, 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 2, 1);
    repeat (17) drive(0, 0, 0, 0);

    drive(0, 1, 0, 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);

    drive(0, 1, 7, 1);
    drive(0, 1, 3, 1);
    drive(0, 1, 15, 1);
    drive(0, 1, 15, 1);

    drive(1, 0, 0, 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 3, 1);
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 4, 0);
    drive(0, 1, 2, 0);
    repeat (30) drive(0, 0, 0, 0);

    repeat (3000) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
